// File: rtl/cmp_pkg.sv
// Shared types for the iterative magnitude comparator: FSM states and the
// one-hot result record.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic agt;
    logic bgt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '0;

  // Builds the one-hot result from a chunk compare outcome.
  function automatic cmp_res_t res_from(input logic eq, input logic agt);
    cmp_res_t r;
    r     = RES_NONE;
    r.eq  = eq;
    r.agt = !eq && agt;
    r.bgt = !eq && !agt;
    return r;
  endfunction

endpackage

// File: rtl/compare_chunk.sv
// Combinational CHUNK-wide unsigned comparator; zero latency, no handshake.
// alarger_o is meaningful only when equal_o is 0.
module compare_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             equal_o,
  output logic             alarger_o
);

  assign equal_o   = (a_i == b_i);
  assign alarger_o = (a_i > b_i);

endmodule

// File: rtl/seq_compare.sv
// Iterative MSB-first magnitude comparator, CHUNK bits per cycle with early exit.
// Latency 1..NCHUNK cycles from accept; one op in flight, result held in DONE until ready_i.
module seq_compare
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = $clog2(NCHUNK + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  input  logic             abort_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             equal_o,
  output logic             alarger_o,
  output logic             blarger_o,
  output logic [CW-1:0]    cnt_o
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_compare: WIDTH must be a non-zero multiple of CHUNK");
  end

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    res_cnt_q;
  cmp_res_t         res_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_eq, chunk_agt;
  logic             accept, last_chunk;

  assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == '0);
  assign accept     = (state_q == IDLE) && valid_i && !abort_i;

  compare_chunk #(.CHUNK(CHUNK)) u_compare_chunk (
    .a_i       (a_chunk),
    .b_i       (b_chunk),
    .equal_o   (chunk_eq),
    .alarger_o (chunk_agt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = RUN;
      end
      RUN: begin
        if (!chunk_eq || last_chunk) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort outranks every transition, including an accept in IDLE.
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      res_cnt_q <= '0;
      res_q     <= RES_NONE;
    end else if (abort_i) begin
      res_cnt_q <= '0;
      res_q     <= RES_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            a_q   <= signed_i ? (a_i ^ SIGN_MASK) : a_i;
            b_q   <= signed_i ? (b_i ^ SIGN_MASK) : b_i;
            idx_q <= IW'(NCHUNK - 1);
            cnt_q <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (!chunk_eq || last_chunk) begin
            res_q     <= res_from(chunk_eq, chunk_agt);
            res_cnt_q <= cnt_q + CW'(1);
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            res_q     <= RES_NONE;
            res_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign equal_o   = res_q.eq;
  assign alarger_o = res_q.agt;
  assign blarger_o = res_q.bgt;
  assign cnt_o     = res_cnt_q;

endmodule

// File: doc/seq_compare.md
Name: seq_compare

Overview:
- Parametrised, iterative magnitude comparator. Compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and stops early at the first differing chunk.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Valid/ready handshake on both input and output sides, plus a synchronous abort.
- Used wherever a wide compare must not sit on a single combinational path, e.g. datapath and branch-compare units.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK; elaboration fails otherwise.
- CHUNK, 4, bits examined per cycle. Range 1..WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local parameter; not overridable.
- CW, $clog2(NCHUNK+1), derived width of the chunk counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- a_i  in  WIDTH  operand A; sampled only at accept.
- b_i  in  WIDTH  operand B; sampled only at accept.
- signed_i  in  1  1 = two's-complement compare; sampled at accept.
- abort_i  in  1  synchronous cancel of the current operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer takes the result.
- equal_o  out  1  A == B.
- alarger_o  out  1  A > B.
- blarger_o  out  1  A < B.
- cnt_o  out  CW  number of chunks examined for this result (1..NCHUNK).

Behaviour:
- Reset values:
  - state = IDLE, so ready_o = 1.
  - valid_o = 0; equal_o, alarger_o, blarger_o = 0; cnt_o = 0.
  - Operand registers = 0.
- Reset mid-operation discards all work immediately; no result is produced.
- States:
  - IDLE: ready_o = 1. valid_i & ready_o is the accept edge.
    - At accept, latch a_i and b_i. If signed_i = 1, invert bit WIDTH-1 of both latched operands so the unsigned chunk compare yields the signed order.
    - At accept, set idx = NCHUNK-1 and cnt = 0, then go to RUN.
  - RUN: ready_o = 0. Each cycle compares chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) and increments cnt.
    - Chunks differ: load alarger or blarger, load cnt_o, go to DONE.
    - Chunks equal and idx == 0: load equal, go to DONE.
    - Otherwise: decrement idx and stay in RUN.
  - DONE: valid_o = 1. Result outputs and cnt_o are registered and stable.
    - ready_i = 1: go to IDLE; clear valid_o, results and cnt_o on the same edge.
- Latency: valid_o rises k edges after the accept edge, where k is the number of chunks examined (1..NCHUNK).
  - Best case 1 cycle; worst case NCHUNK cycles (equal operands, or only chunk 0 differs).
- Result encoding:
  - Exactly one of equal_o, alarger_o, blarger_o is 1 whenever valid_o = 1.
  - All three are 0 whenever valid_o = 0.
- Throughput: ready_o is 0 in RUN and DONE, so there is one operation in flight. The earliest next accept is the cycle after the DONE→IDLE edge.
- Input stability: a_i, b_i and signed_i may change freely after accept without affecting the result. valid_i outside IDLE is ignored, not queued.
- abort_i has the highest priority after reset. In any state it forces IDLE on the next edge and clears valid_o, results and cnt_o.
  - abort_i together with valid_i in IDLE: the request is not accepted.
  - abort_i in DONE together with ready_i: treated as an abort; the result counts as not delivered.
- Backpressure: in DONE with ready_i = 0, hold all outputs indefinitely.
- Degenerate case CHUNK = WIDTH: the compare takes a single cycle, so cnt_o is always 1.

Decomposition:
- Package cmp_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_e;
  - typedef struct packed {eq, agt, bgt} cmp_res_t;
  - constant RES_NONE = all-zero cmp_res_t.
- Sub-module compare_chunk: combinational CHUNK-wide unsigned comparator with outputs equal_o / alarger_o. It generalises the existing per-bit compare; one instance is used, muxed by idx.

Test Plan (WIDTH=32, CHUNK=4):
- Equal operands: a = b = 0xDEADBEEF, signed 0 → valid_o after 8 cycles; equal_o = 1, cnt_o = 8; ready_o returns 1 the cycle after ready_i.
- MSB differs:
  - a = 0x80000000, b = 0x7FFFFFFF, signed 0 → alarger_o after 1 cycle, cnt_o = 1.
  - Same operands, signed 1 → blarger_o, cnt_o = 1.
  - a = 0xFFFFFFFF, b = 0x00000001, signed 1 → blarger_o, cnt_o = 1.
- LSB differs: a = 0x00000001, b = 0x00000002 → blarger_o after 8 cycles, cnt_o = 8. Change a_i and b_i during RUN → result unchanged.
- Backpressure: hold ready_i = 0 for 5 cycles in DONE while pulsing valid_i → outputs stable, ready_o = 0, no second accept. Then ready_i = 1 → IDLE; the next request computes correctly.
- Abort: a = 0x12345678, b = 0x12345679, abort_i on the 3rd RUN cycle → valid_o never rises, ready_o = 1 the next cycle. A following request with a = 5, b = 5 gives equal_o = 1, cnt_o = 8.
- Reset mid-run: drive rst_ni low during RUN → valid_o, results and cnt_o are 0 immediately (asynchronously). After release ready_o = 1 and no stale result appears.
